nr_recip_seq: RTL and testbench

Sequential Newton-Raphson reciprocal engine for the sigmoid datapath. It accepts an exponential term e (Q4.16, unsigned) and forms the divisor d = 1.0 + e. It generates a piecewise-linear seed for 1/d, then runs ITERS Newton-Raphson refinements through one time-shared square/multiply datapath. It is the driving side of the NR step: it produces the seed/exp operand pair, iterates the step, and returns y ≈ 1/(1+e), which is the sigmoid when e = exp(−x).

---
 rtl/nr_recip_seq.sv | 167 ++++++++++++++++
 tb/tb_nr_recip_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nr_recip_seq.sv
// nr_recip_seq: sequential Newton-Raphson reciprocal, recip_out ~= 1/(1+exp_in), Q4.16 in and out.
// Build option NR_RECIP_EXT_SEED_EN adds seed_in and replaces the internal PWL seed with it.
module nr_recip_seq #(
    parameter int ITERS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] recip_out,
`ifdef NR_RECIP_EXT_SEED_EN
    input  logic [19:0] seed_in,
`endif
    output logic [2:0]  o_dbg_state
);

    localparam int CW = $clog2(ITERS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEED = 3'd1,
        S_SQ   = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [20:0]   r_d;
    logic [19:0]   r_y;
    logic [39:0]   r_sq;
    logic [CW-1:0] r_cnt;
    logic [19:0]   r_recip;

    logic          w_accept;
    logic [CW-1:0] w_cnt_inc;
    logic          w_last;
    logic [19:0]   w_two_y;
    logic [51:0]   w_sqd;
    logic [19:0]   w_y_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid/recip_out hold in DONE until out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SEED;
                end
            end
            S_SEED: w_next = S_SQ;
            S_SQ:   w_next = S_MUL;
            S_MUL:  w_next = w_last ? S_DONE : S_SQ;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            w_accept  = 1'b0;
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_last    = (w_cnt_inc == CW'(ITERS));

    // Only bits [51:32] of the 60-bit NR difference are kept, so the product is needed mod 2^52.
    assign w_two_y  = {r_y[18:0], 1'b0};
    assign w_sqd    = {12'd0, r_sq} * {31'd0, r_d};
    assign w_y_next = 20'(({w_two_y, 32'd0} - w_sqd) >> 32);

`ifdef NR_RECIP_EXT_SEED_EN
    logic [19:0] r_seed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed <= 20'd0;
        end else if (w_accept) begin
            r_seed <= seed_in;
        end
    end
`else
    logic [2:0]  w_sh;
    logic [15:0] w_m;
    logic [32:0] w_prod;
    logic [19:0] w_seed_y;

    // Normalising shift = (MSB index of d) - 15; d >= 1.0 so the MSB sits in bits 16..20.
    always_comb begin
        w_sh = 3'd1;
        if (r_d[20]) begin
            w_sh = 3'd5;
        end else if (r_d[19]) begin
            w_sh = 3'd4;
        end else if (r_d[18]) begin
            w_sh = 3'd3;
        end else if (r_d[17]) begin
            w_sh = 3'd2;
        end
    end

    assign w_m      = 16'(r_d >> w_sh);
    assign w_prod   = 33'd123362 * {17'd0, w_m};
    assign w_seed_y = 20'((33'd185042 - (w_prod >> 16)) >> w_sh);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d     <= 21'd0;
            r_y     <= 20'd0;
            r_sq    <= 40'd0;
            r_cnt   <= '0;
            r_recip <= 20'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_d   <= 21'h10000 + {1'b0, exp_in};
                        r_cnt <= '0;
                    end
                end
                S_SEED: begin
`ifdef NR_RECIP_EXT_SEED_EN
                    r_y <= r_seed;
`else
                    r_y <= w_seed_y;
`endif
                end
                S_SQ: r_sq <= {20'd0, r_y} * {20'd0, r_y};
                S_MUL: begin
                    r_y   <= w_y_next;
                    r_cnt <= w_cnt_inc;
                    if (w_last) begin
                        r_recip <= w_y_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign recip_out   = r_recip;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nr_recip_seq.sv
// Bench for nr_recip_seq: reference vectors, backpressure and reset corners,
// plus 1000 random operands against an arithmetic model of the seed and NR step.
module tb_nr_recip_seq;

    localparam int ITERS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] recip_out;
    logic [2:0]  dbg_state;
`ifdef NR_RECIP_EXT_SEED_EN
    logic [19:0] seed_in;
`endif

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_ys [0:ITERS];

    typedef struct {
        logic [19:0] e;
        logic [19:0] s;
        logic [19:0] y0;
        logic [19:0] y1;
        logic [19:0] y2;
    } vec_t;

    vec_t vecs [0:1];

    always #5 clk = ~clk;

    nr_recip_seq #(.ITERS(ITERS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_in     (exp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .recip_out  (recip_out),
`ifdef NR_RECIP_EXT_SEED_EN
        .seed_in    (seed_in),
`endif
        .o_dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // PWL seed straight from its definition: normalise d to [0.5,1), line 48/17 - 32/17*m, denormalise.
    function automatic logic [19:0] ref_seed(input logic [20:0] d);
        int p;
        longint unsigned m;
        longint unsigned s;
        p = 20;
        while (p > 16 && d[p] == 1'b0) p--;
        m = longint'(d) >> (p - 15);
        s = 64'd185042 - ((64'd123362 * m) >> 16);
        return 20'(s >> (p - 15));
    endfunction

    function automatic logic [19:0] ref_step(input logic [19:0] y, input logic [20:0] d);
        logic [63:0] two_y;
        logic [63:0] sq;
        logic [63:0] t;
        two_y = (64'(y) * 64'd2) % (64'd1 << 20);
        sq    = 64'(y) * 64'(y);
        t     = ((two_y << 32) - sq * 64'(d)) & ((64'd1 << 60) - 64'd1);
        return 20'(t >> 32);
    endfunction

    task automatic build_exp(input logic [19:0] e, input logic [19:0] s);
        logic [20:0] d;
        d = 21'h10000 + 21'(e);
`ifdef NR_RECIP_EXT_SEED_EN
        exp_ys[0] = s;
`else
        exp_ys[0] = ref_seed(d);
        if (s != 20'd0) exp_ys[0] = ref_seed(d);
`endif
        for (int i = 1; i <= ITERS; i++) exp_ys[i] = ref_step(exp_ys[i-1], d);
    endtask

    task automatic run_op(input logic [19:0] e, input logic [19:0] s, input int hold, input string tag);
        check({tag, "_in_ready_idle"}, 40'(in_ready), 40'd1);
        in_valid = 1'b1;
        exp_in   = e;
`ifdef NR_RECIP_EXT_SEED_EN
        seed_in  = s;
`endif
        tick();
        in_valid = 1'b0;
        exp_in   = 20'($urandom);
`ifdef NR_RECIP_EXT_SEED_EN
        seed_in  = 20'($urandom);
`endif
        tick();
        check({tag, "_seed"}, 40'(dut.r_y), 40'(exp_ys[0]));
        check({tag, "_in_ready_busy"}, 40'(in_ready), 40'd0);
        for (int i = 1; i <= ITERS; i++) begin
            tick();
            tick();
            check($sformatf("%s_iter%0d_y", tag, i), 40'(dut.r_y), 40'(exp_ys[i]));
            check($sformatf("%s_iter%0d_out_valid", tag, i), 40'(out_valid), 40'(i == ITERS));
        end
        check({tag, "_recip"}, 40'(recip_out), 40'(exp_ys[ITERS]));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            exp_in   = 20'($urandom);
            tick();
            check({tag, "_hold_out_valid"}, 40'(out_valid), 40'd1);
            check({tag, "_hold_recip"}, 40'(recip_out), 40'(exp_ys[ITERS]));
            check({tag, "_hold_in_ready"}, 40'(in_ready), 40'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ret_in_ready"}, 40'(in_ready), 40'd1);
        check({tag, "_ret_out_valid"}, 40'(out_valid), 40'd0);
        check({tag, "_ret_recip_held"}, 40'(recip_out), 40'(exp_ys[ITERS]));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] e;
        logic [19:0] s;
        logic [20:0] d;
        logic [19:0] ideal;
        int diff;

`ifdef NR_RECIP_EXT_SEED_EN
        vecs[0] = '{e: 20'h00000, s: 20'h08000, y0: 20'h08000, y1: 20'd49152, y2: 20'd61440};
        vecs[1] = '{e: 20'h00000, s: 20'h00000, y0: 20'h00000, y1: 20'd0,     y2: 20'd0};
        seed_in = 20'd0;
`else
        vecs[0] = '{e: 20'h00000, s: 20'h0, y0: 20'h0F0F0, y1: 20'd65309, y2: 20'h0FFFF};
        vecs[1] = '{e: 20'h10000, s: 20'h0, y0: 20'd30840, y1: 20'd32654, y2: 20'h07FFF};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        exp_in    = 20'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_in_ready", 40'(in_ready), 40'd0);
            check("reset_out_valid", 40'(out_valid), 40'd0);
            check("reset_recip", 40'(recip_out), 40'd0);
        end
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", 40'(in_ready), 40'd1);
        check("post_reset_out_valid", 40'(out_valid), 40'd0);

        for (int i = 0; i < 2; i++) begin
            exp_ys[0] = vecs[i].y0;
            exp_ys[1] = vecs[i].y1;
            exp_ys[2] = vecs[i].y2;
            run_op(vecs[i].e, vecs[i].s, 0, $sformatf("vec%0d", i));
        end

        build_exp(20'h00000, 20'h08000);
        run_op(20'h00000, 20'h08000, 10, "backpressure");

        check("midflight_in_ready", 40'(in_ready), 40'd1);
        in_valid = 1'b1;
        exp_in   = 20'h12345;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mul_out_valid", 40'(out_valid), 40'd0);
        check("rst_mul_recip", 40'(recip_out), 40'd0);
        check("rst_mul_in_ready", 40'(in_ready), 40'd0);
        check("rst_mul_y", 40'(dut.r_y), 40'd0);
        rst = 1'b0;
        tick();
        check("rst_release_in_ready", 40'(in_ready), 40'd1);
        check("rst_release_out_valid", 40'(out_valid), 40'd0);
        build_exp(20'h00000, 20'h08000);
        run_op(20'h00000, 20'h08000, 0, "after_rst");

        for (int n = 0; n < 1000; n++) begin
            e = 20'($urandom_range(0, 20'hFFFFF));
            s = 20'($urandom);
            build_exp(e, s);
            run_op(e, s, $urandom_range(0, 2), "rand");
`ifndef NR_RECIP_EXT_SEED_EN
            d     = 21'h10000 + 21'(e);
            ideal = 20'((64'd1 << 32) / 64'(d));
            diff  = int'(recip_out) - int'(ideal);
            checks++;
            if (diff < -2 || diff > 2) begin
                errors++;
                $display("FAIL rand_accuracy e=0x%0h actual=%0d required=%0d+-2", e, recip_out, ideal);
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
